// File: rtl/dtmr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtmr_pkg
// Purpose  : Shared definitions for the DTMR command receiver:
//            - default frame header byte
//            - deframer FSM state encoding
//            - bit positions of the fields inside the two payload bytes
//            - error-rate saturation limit
//            - frame validity check (even parity over the payload, and the
//              reserved field must be zero)
// Revision : 1.0 - initial release
// ============================================================================
package dtmr_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_B1     = 2'd1,
        ST_B2     = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // byte1 = {speed, dir}
    localparam int SPEED_MSB = 7;
    localparam int SPEED_LSB = 4;
    localparam int DIR_MSB   = 3;
    localparam int DIR_LSB   = 0;

    // byte2 = {mode, rsvd, par}
    localparam int MODE_MSB  = 7;
    localparam int MODE_LSB  = 6;
    localparam int RSVD_MSB  = 5;
    localparam int RSVD_LSB  = 1;
    localparam int PAR_BIT   = 0;

    localparam int ERR_RATE_MAX = 15;

    // The parity bit is part of byte2, so XOR over all 16 payload bits
    // is zero exactly when parity is even.
    function automatic logic frame_good(input logic [7:0] b1, input logic [7:0] b2);
        return ((^{b1, b2}) == 1'b0) && (b2[RSVD_MSB:RSVD_LSB] == '0);
    endfunction

endpackage : dtmr_pkg
`default_nettype wire

// File: rtl/err_window.sv
`default_nettype none
// ============================================================================
// Module   : err_window
// Purpose  : Sliding-window bad-frame counter. Each push shifts one result
//            bit (1 = bad) into a WINDOW-deep history and adjusts the running
//            count by the bit entering minus the bit leaving. The count is
//            reported saturated to 4 bits.
// Ports    : clk      - system clock, rising edge
//            rst      - asynchronous reset, active low
//            push     - a frame result is available this cycle
//            bad      - result of that frame (1 = bad)
//            err_rate - bad frames in the last WINDOW frames, saturated at 15
// Revision : 1.0 - initial release
// ============================================================================
module err_window
    import dtmr_pkg::*;
#(
    parameter int WINDOW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       bad,
    output logic [3:0] err_rate
);

    localparam int CW = $clog2(WINDOW + 1);
    // Comparison width: never narrower than the 4-bit saturation limit.
    localparam int EW = (CW > 4) ? CW : 4;

    logic [WINDOW-1:0] hist_q, hist_d;
    logic [CW-1:0]     cnt_q,  cnt_d;
    logic [EW-1:0]     cnt_ext;

    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (push) begin
            hist_d = {hist_q[WINDOW-2:0], bad};
            // The outgoing bit was counted when it entered, so no underflow.
            cnt_d  = cnt_q + CW'(bad) - CW'(hist_q[WINDOW-1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_ext  = EW'(cnt_q);
    assign err_rate = (cnt_ext > EW'(ERR_RATE_MAX)) ? 4'(ERR_RATE_MAX) : cnt_ext[3:0];

endmodule : err_window
`default_nettype wire

// File: rtl/cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : cmd_rx
// Purpose  : Command receiver / deframer upstream of the DTMR core. Hunts for
//            3-byte frames {HEADER, {speed,dir}, {mode,rsvd,par}}, validates
//            them and holds the last good speed/dir/mode. Tracks bad frames
//            over a sliding window of recent frames.
//            Optional build macro CMD_RX_TIMEOUT_EN adds a link watchdog:
//            after TIMEOUT cycles without a good frame, speed is forced to 0
//            and link_timeout is raised until the next good frame.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous reset, active low
//            rx_valid     - rx_data valid
//            rx_data      - incoming link byte
//            rx_ready     - byte accepted when rx_valid && rx_ready
//            speed        - last good commanded speed
//            dir          - last good commanded direction
//            mode         - last good operation mode
//            err_rate     - bad frames in the last WINDOW frames (sat. 15)
//            frame_ok     - one-cycle pulse on good frame commit
//            frame_err    - one-cycle pulse on bad frame commit
//            link_timeout - watchdog active (0 without CMD_RX_TIMEOUT_EN)
// Revision : 1.0 - initial release
// ============================================================================
module cmd_rx
    import dtmr_pkg::*;
#(
    parameter int         WINDOW  = 16,
    parameter int         TIMEOUT = 1024,
    parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic [3:0] speed,
    output logic [3:0] dir,
    output logic [1:0] mode,
    output logic [3:0] err_rate,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       link_timeout
);

    // Elaboration-time parameter sanity checks.
    if (WINDOW < 2) begin : g_bad_window
        $error("cmd_rx: WINDOW must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cmd_rx: TIMEOUT must be at least 1");
    end

    state_t     state_q, state_d;
    logic [7:0] byte1_q, byte1_d;
    logic [7:0] byte2_q, byte2_d;
    logic [3:0] speed_q, speed_d;
    logic [3:0] dir_q,   dir_d;
    logic [1:0] mode_q,  mode_d;
    logic       frame_ok_q,  frame_ok_d;
    logic       frame_err_q, frame_err_d;

    logic       accept;
    logic       commit;
    logic       good;
    logic       good_commit;
    logic       timeout_hit;

    // rx_ready is held low throughout reset, not just in COMMIT.
    assign rx_ready    = rst && (state_q != ST_COMMIT);
    assign accept      = rx_valid && rx_ready;
    assign commit      = (state_q == ST_COMMIT);
    assign good        = frame_good(byte1_q, byte2_q);
    assign good_commit = commit && good;

    // ------------------------------------------------------------------
    // Deframer FSM and command registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        byte1_d     = byte1_q;
        byte2_d     = byte2_q;
        speed_d     = speed_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                // Non-header bytes are silently dropped while hunting.
                if (accept && (rx_data == HEADER)) begin
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                // No resync: a HEADER value here is ordinary payload.
                if (accept) begin
                    byte1_d = rx_data;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (accept) begin
                    byte2_d = rx_data;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_HUNT;
                if (good) begin
                    speed_d    = byte1_q[SPEED_MSB:SPEED_LSB];
                    dir_d      = byte1_q[DIR_MSB:DIR_LSB];
                    mode_d     = byte2_q[MODE_MSB:MODE_LSB];
                    frame_ok_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Safe stop on watchdog expiry; never true on a good commit.
        if (timeout_hit) begin
            speed_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HUNT;
            byte1_q     <= '0;
            byte2_q     <= '0;
            speed_q     <= '0;
            dir_q       <= '0;
            mode_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte1_q     <= byte1_d;
            byte2_q     <= byte2_d;
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign speed     = speed_q;
    assign dir       = dir_q;
    assign mode      = mode_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // Link watchdog (optional)
    // ------------------------------------------------------------------
`ifdef CMD_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          link_timeout_q, link_timeout_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (good_commit) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        // Bad frames leave the counter running, so they cannot clear it.
        timeout_hit    = !good_commit && (to_cnt_d == TW'(TIMEOUT));
        link_timeout_d = timeout_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q       <= '0;
            link_timeout_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            link_timeout_q <= link_timeout_d;
        end
    end

    assign link_timeout = link_timeout_q;
`else
    assign timeout_hit  = 1'b0;
    assign link_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sliding-window error counter
    // ------------------------------------------------------------------
    err_window #(
        .WINDOW   (WINDOW)
    ) u_err_window (
        .clk      (clk),
        .rst      (rst),
        .push     (commit),
        .bad      (!good),
        .err_rate (err_rate)
    );

endmodule : cmd_rx
`default_nettype wire
